// File: rtl/multiplexer_8to1_if.sv
// Bus bundle for the 8-to-1 multiplexer: enable, data, select and result signals.
interface multiplexer_8to1_if #(
    parameter int unsigned WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic [WIDTH-1:0] I3;
    logic [WIDTH-1:0] I4;
    logic [WIDTH-1:0] I5;
    logic [WIDTH-1:0] I6;
    logic [WIDTH-1:0] I7;
    logic             S0;
    logic             S1;
    logic             S2;
    logic [WIDTH-1:0] O0;
    logic [WIDTH-1:0] O0_comb;
    logic             O0_valid;

    modport master (
        output en, I0, I1, I2, I3, I4, I5, I6, I7, S0, S1, S2,
        input  O0, O0_comb, O0_valid
    );

    modport slave (
        input  en, I0, I1, I2, I3, I4, I5, I6, I7, S0, S1, S2,
        output O0, O0_comb, O0_valid
    );
endinterface

// File: rtl/multiplexer_8to1.sv
// 8-to-1 multiplexer with an always-combinational result and an optional
// registered result (OUT_REG=1) that carries a one-cycle valid flag.
module multiplexer_8to1 #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          OUT_REG = 1'b1
) (
    input logic               clk,
    input logic               rst,
    multiplexer_8to1_if.slave bus
);
    logic [2:0]       sel;
    logic [WIDTH-1:0] o0_comb;

    // S0 is the MSB, S2 the LSB.
    assign sel = {bus.S0, bus.S1, bus.S2};

    // Pure combinational selection; every select code maps to one input.
    always_comb begin
        o0_comb = bus.I0;
        unique case (sel)
            3'd0: o0_comb = bus.I0;
            3'd1: o0_comb = bus.I1;
            3'd2: o0_comb = bus.I2;
            3'd3: o0_comb = bus.I3;
            3'd4: o0_comb = bus.I4;
            3'd5: o0_comb = bus.I5;
            3'd6: o0_comb = bus.I6;
            3'd7: o0_comb = bus.I7;
        endcase
    end

    assign bus.O0_comb = o0_comb;

    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] o0_q;
        logic             valid_q;

        // Capture the selected data when enabled; valid tracks en every edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                o0_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= bus.en;
                if (bus.en) begin
                    o0_q <= o0_comb;
                end
            end
        end

        assign bus.O0       = o0_q;
        assign bus.O0_valid = valid_q;
    end else begin : g_comb
        // Combinational form: result always fresh outside reset.
        assign bus.O0       = o0_comb;
        assign bus.O0_valid = ~rst;
    end
endmodule

// File: tb/tb_multiplexer_8to1.sv
// Self-checking bench: three instances (1-bit registered, 8-bit registered,
// 1-bit combinational) driven from one stimulus stream and compared against
// an array-indexed reference model.
module tb_multiplexer_8to1;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multiplexer_8to1_if #(.WIDTH(1)) bus_a ();
    multiplexer_8to1_if #(.WIDTH(8)) bus_b ();
    multiplexer_8to1_if #(.WIDTH(1)) bus_c ();

    multiplexer_8to1 #(.WIDTH(1), .OUT_REG(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    multiplexer_8to1 #(.WIDTH(8), .OUT_REG(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    multiplexer_8to1 #(.WIDTH(1), .OUT_REG(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int total = 0;
    int bad   = 0;

    // Reference state: data table, select index and registered expectations.
    logic [7:0] data [8];
    int         sel_idx;
    logic       en_v;
    logic [7:0] exp_reg8;
    logic       exp_reg1;
    logic       exp_valid;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Push the current data/select/enable into all three instances.
    task automatic drive();
        bus_a.en = en_v; bus_b.en = en_v; bus_c.en = en_v;
        bus_a.S0 = 1'((sel_idx / 4) % 2); bus_a.S1 = 1'((sel_idx / 2) % 2); bus_a.S2 = 1'(sel_idx % 2);
        bus_b.S0 = bus_a.S0; bus_b.S1 = bus_a.S1; bus_b.S2 = bus_a.S2;
        bus_c.S0 = bus_a.S0; bus_c.S1 = bus_a.S1; bus_c.S2 = bus_a.S2;
        bus_b.I0 = data[0]; bus_b.I1 = data[1]; bus_b.I2 = data[2]; bus_b.I3 = data[3];
        bus_b.I4 = data[4]; bus_b.I5 = data[5]; bus_b.I6 = data[6]; bus_b.I7 = data[7];
        bus_a.I0 = data[0][0]; bus_a.I1 = data[1][0]; bus_a.I2 = data[2][0];
        bus_a.I3 = data[3][0]; bus_a.I4 = data[4][0]; bus_a.I5 = data[5][0];
        bus_a.I6 = data[6][0]; bus_a.I7 = data[7][0];
        bus_c.I0 = data[0][0]; bus_c.I1 = data[1][0]; bus_c.I2 = data[2][0];
        bus_c.I3 = data[3][0]; bus_c.I4 = data[4][0]; bus_c.I5 = data[5][0];
        bus_c.I6 = data[6][0]; bus_c.I7 = data[7][0];
    endtask

    // Checks of the combinational outputs between edges.
    task automatic chk_comb(input string tag);
        chk({tag, "/comb_a"}, {7'd0, bus_a.O0_comb}, {7'd0, data[sel_idx][0]});
        chk({tag, "/comb_b"}, bus_b.O0_comb, data[sel_idx]);
        chk({tag, "/comb_c"}, {7'd0, bus_c.O0_comb}, {7'd0, data[sel_idx][0]});
        chk({tag, "/o0_c"}, {7'd0, bus_c.O0}, {7'd0, data[sel_idx][0]});
        chk({tag, "/valid_c"}, {7'd0, bus_c.O0_valid}, {7'd0, ~rst});
    endtask

    // Checks of the registered outputs against the model.
    task automatic chk_reg(input string tag);
        chk({tag, "/o0_a"}, {7'd0, bus_a.O0}, {7'd0, exp_reg1});
        chk({tag, "/o0_b"}, bus_b.O0, exp_reg8);
        chk({tag, "/valid_a"}, {7'd0, bus_a.O0_valid}, {7'd0, exp_valid});
        chk({tag, "/valid_b"}, {7'd0, bus_b.O0_valid}, {7'd0, exp_valid});
    endtask

    // One cycle: drive at edge+1, check comb, advance the model at the edge, check regs.
    task automatic step(input string tag);
        drive();
        #1;
        chk_comb(tag);
        @(posedge clk);
        exp_valid = en_v;
        if (en_v) begin
            exp_reg8 = data[sel_idx];
            exp_reg1 = data[sel_idx][0];
        end
        #1;
        chk_reg(tag);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) data[k] = 8'h00;
        sel_idx   = 0;
        en_v      = 1'b0;
        exp_reg8  = 8'h00;
        exp_reg1  = 1'b0;
        exp_valid = 1'b0;
        drive();

        // Reset state, across an edge with en high.
        en_v = 1'b1;
        drive();
        @(posedge clk);
        #1;
        chk_reg("reset");
        chk({"reset", "/comb_b"}, bus_b.O0_comb, 8'h00);
        rst = 1'b0;
        en_v = 1'b0;
        step("post_reset_idle");

        // Walking one across every input and every select code.
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 8; s++) begin
                for (int j = 0; j < 8; j++) data[j] = (j == k) ? 8'h01 : 8'h00;
                sel_idx = s;
                en_v    = 1'b1;
                step($sformatf("walk_k%0d_s%0d", k, s));
            end
        end

        // Hold: capture I3=1, then disable and move select to 0.
        for (int j = 0; j < 8; j++) data[j] = (j == 3) ? 8'hff : 8'h00;
        sel_idx = 3;
        en_v    = 1'b1;
        step("hold_capture");
        sel_idx = 0;
        en_v    = 1'b0;
        step("hold_keep");
        chk("hold_o0_literal", {7'd0, bus_a.O0}, 8'h01);

        // Asynchronous reset pulse between edges while O0=1.
        #2;
        rst = 1'b1;
        #1;
        exp_reg8  = 8'h00;
        exp_reg1  = 1'b0;
        exp_valid = 1'b0;
        chk_reg("async_rst");
        data[0] = 8'h5a;
        drive();
        #1;
        chk({"async_rst", "/comb_b"}, bus_b.O0_comb, 8'h5a);
        chk({"async_rst", "/valid_c"}, {7'd0, bus_c.O0_valid}, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sel_idx = 3;
        en_v    = 1'b1;
        step("after_rst");
        chk("after_rst_o0_literal", {7'd0, bus_a.O0}, 8'h01);

        // 8-bit pattern sweep: expected value is 0x11*(sel+1).
        for (int j = 0; j < 8; j++) data[j] = 8'(8'h11 * (j + 1));
        for (int s = 0; s < 8; s++) begin
            sel_idx = s;
            en_v    = 1'b1;
            step($sformatf("w8_s%0d", s));
            chk($sformatf("w8_formula_s%0d", s), bus_b.O0, 8'(8'h11 * (s + 1)));
        end

        // Randomised data, select and enable.
        for (int n = 0; n < 60; n++) begin
            for (int j = 0; j < 8; j++) data[j] = 8'($urandom);
            sel_idx = int'($urandom_range(0, 7));
            en_v    = 1'($urandom_range(0, 1));
            step($sformatf("rand_%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
